// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: memory-mapped CPU front end for a byte UART.
// Three word registers: TXD (transmit byte), RXD (received byte) and
// CON (interrupt enables plus sticky status flags). The UART handshake
// lines are synchronised into this clock domain before use.
module uart_bus_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_enable,
    input  logic        tx_status,
    input  logic [7:0]  rx_data,
    input  logic        rx_status,
    output logic        rx_enable
);

    localparam logic [31:0] ADDR_TXD = BASE_ADDR;
    localparam logic [31:0] ADDR_RXD = BASE_ADDR + 32'd4;
    localparam logic [31:0] ADDR_CON = BASE_ADDR + 32'd8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_t;

    tx_state_t   r_state;
    tx_state_t   w_state_next;

    logic        r_tx_meta;
    logic        r_tx_s;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_s_d;

    logic [7:0]  r_tx_data;
    logic [7:0]  r_rx_buf;
    logic        r_rx_ready;
    logic        r_rx_overrun;
    logic        r_tx_done;
    logic        r_tx_overrun;
    logic        r_tx_int_en;
    logic        r_rx_int_en;

    logic        w_sel_txd;
    logic        w_sel_rxd;
    logic        w_sel_con;
    logic        w_wr_txd;
    logic        w_wr_con;
    logic        w_rd_rxd;
    logic        w_rd_con;
    logic        w_rx_rise;
    logic        w_tx_accept;
    logic        w_tx_refuse;
    logic        w_tx_done_set;
    logic        w_tx_enable;
    logic        w_tx_busy;
    logic        w_unused_wdata;

    // Only the low byte of write data is ever consumed.
    assign w_unused_wdata = ^write_data[31:8];

    assign w_sel_txd = (addr == ADDR_TXD);
    assign w_sel_rxd = (addr == ADDR_RXD);
    assign w_sel_con = (addr == ADDR_CON);
    assign w_wr_txd  = mem_write & w_sel_txd;
    assign w_wr_con  = mem_write & w_sel_con;
    assign w_rd_rxd  = mem_read & w_sel_rxd;
    assign w_rd_con  = mem_read & w_sel_con;

    // A new receive byte is signalled by the first cycle rx_s is seen high.
    assign w_rx_rise = r_rx_s & ~r_rx_s_d;
    assign w_tx_busy = (r_state != TX_IDLE);

    // Two-flop synchronisers; reset to the idle level (1) so that no
    // spurious edge is seen when reset is released.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_tx_meta <= 1'b1;
            r_tx_s    <= 1'b1;
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_s_d  <= 1'b1;
        end else begin
            r_tx_meta <= tx_status;
            r_tx_s    <= r_tx_meta;
            r_rx_meta <= rx_status;
            r_rx_s    <= r_rx_meta;
            r_rx_s_d  <= r_rx_s;
        end
    end

    // Transmit FSM state register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Transmit FSM next state: accept a byte only when idle and the UART
    // reports idle, pulse the UART once, then follow its busy/idle cycle.
    always_comb begin
        w_state_next  = r_state;
        w_tx_accept   = 1'b0;
        w_tx_done_set = 1'b0;
        w_tx_enable   = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (w_wr_txd && r_tx_s) begin
                    w_tx_accept  = 1'b1;
                    w_state_next = TX_START;
                end
            end
            TX_START: begin
                w_tx_enable  = 1'b1;
                w_state_next = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (!r_tx_s) begin
                    w_state_next = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (r_tx_s) begin
                    w_tx_done_set = 1'b1;
                    w_state_next  = TX_IDLE;
                end
            end
            default: begin
                w_state_next = TX_IDLE;
            end
        endcase
    end

    assign w_tx_refuse = w_wr_txd & ~w_tx_accept;

    // Data registers, sticky flags and interrupt enables. Set events take
    // priority over read-to-clear so no event is ever lost.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_tx_data    <= 8'd0;
            r_rx_buf     <= 8'd0;
            r_rx_ready   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_tx_done    <= 1'b0;
            r_tx_overrun <= 1'b0;
            r_tx_int_en  <= 1'b0;
            r_rx_int_en  <= 1'b0;
        end else begin
            if (w_tx_accept) begin
                r_tx_data <= write_data[7:0];
            end
            if (w_rx_rise) begin
                r_rx_buf <= rx_data;
            end

            if (w_rx_rise) begin
                r_rx_ready <= 1'b1;
            end else if (w_rd_rxd) begin
                r_rx_ready <= 1'b0;
            end

            // A byte arriving on the same edge that the CPU drains RXD is
            // not an overrun: the previous byte was consumed.
            if (w_rx_rise && r_rx_ready && !w_rd_rxd) begin
                r_rx_overrun <= 1'b1;
            end else if (w_rd_con) begin
                r_rx_overrun <= 1'b0;
            end

            if (w_tx_done_set) begin
                r_tx_done <= 1'b1;
            end else if (w_rd_con) begin
                r_tx_done <= 1'b0;
            end

            if (w_tx_refuse) begin
                r_tx_overrun <= 1'b1;
            end else if (w_rd_con) begin
                r_tx_overrun <= 1'b0;
            end

            if (w_wr_con) begin
                r_tx_int_en <= write_data[0];
                r_rx_int_en <= write_data[1];
            end
        end
    end

    // CPU read mux; zero unless a mapped register is being read.
    always_comb begin
        read_data = 32'd0;
        if (mem_read) begin
            if (w_sel_txd) begin
                read_data = {24'd0, r_tx_data};
            end else if (w_sel_rxd) begin
                read_data = {24'd0, r_rx_buf};
            end else if (w_sel_con) begin
                read_data = {25'd0, r_tx_overrun, r_rx_overrun, w_tx_busy,
                             r_rx_ready, r_tx_done, r_rx_int_en, r_tx_int_en};
            end
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_enable = w_tx_enable;
    assign irq       = (r_tx_int_en & r_tx_done) | (r_rx_int_en & r_rx_ready);
    assign rx_enable = ~reset;

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Scoreboard bench for uart_bus_ctrl: stimulus tasks update a
// transaction-level model and queue expected read data / transmitted
// bytes; a monitor pops and compares whenever the DUT presents them.
module tb_uart_bus_ctrl;

    localparam logic [31:0] BASE = 32'h40000018;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] RXD  = BASE + 32'd4;
    localparam logic [31:0] CON  = BASE + 32'd8;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'd0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_status = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_status = 1'b0;
    logic        rx_enable;

    uart_bus_ctrl #(.BASE_ADDR(BASE)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .addr       (addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .write_data (write_data),
        .read_data  (read_data),
        .irq        (irq),
        .tx_data    (tx_data),
        .tx_enable  (tx_enable),
        .tx_status  (tx_status),
        .rx_data    (rx_data),
        .rx_status  (rx_status),
        .rx_enable  (rx_enable)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rd_q[$];
    string       rd_name_q[$];
    logic [7:0]  tx_q[$];

    // Reference model: register contents and flags at transaction level.
    bit [7:0] m_tx_data, m_rx_buf;
    bit m_tx_done, m_rx_ready, m_rx_ovr, m_tx_ovr, m_tx_ie, m_rx_ie;
    bit m_busy;
    bit m_line_idle = 1'b1;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    function automatic logic [31:0] con_val();
        return {25'd0, m_tx_ovr, m_rx_ovr, m_busy, m_rx_ready, m_tx_done, m_rx_ie, m_tx_ie};
    endfunction

    // Monitor: compares whatever the DUT presents against queued expectations.
    always @(negedge sysclk) begin : monitor
        logic [31:0] e;
        string       nm;
        logic [7:0]  eb;
        if (mem_read) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got %h expected no read", read_data);
            end else begin
                e  = rd_q.pop_front();
                nm = rd_name_q.pop_front();
                check(nm, read_data, e);
            end
        end else begin
            check("rd_idle_zero", read_data, 32'd0);
        end
        if (tx_enable) begin
            if (tx_q.size() == 0) begin
                n_checks++;
                $display("FAIL tx_unexpected: got tx_enable=1 data %h expected no send", tx_data);
            end else begin
                eb = tx_q.pop_front();
                check("tx_data", {24'd0, tx_data}, {24'd0, eb});
            end
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic bus_read(logic [31:0] a, logic [31:0] exp, string nm);
        addr = a;
        mem_read = 1'b1;
        rd_q.push_back(exp);
        rd_name_q.push_back(nm);
        tick();
        mem_read = 1'b0;
        addr = 32'd0;
    endtask

    task automatic bus_write(logic [31:0] a, logic [31:0] d);
        addr = a;
        write_data = d;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        addr = 32'd0;
    endtask

    task automatic read_con();
        bus_read(CON, con_val(), "con");
        m_tx_done = 0; m_rx_ovr = 0; m_tx_ovr = 0;
    endtask

    task automatic read_rxd();
        bus_read(RXD, {24'd0, m_rx_buf}, "rxd");
        m_rx_ready = 0;
    endtask

    task automatic read_txd();
        bus_read(TXD, {24'd0, m_tx_data}, "txd");
    endtask

    task automatic write_con(logic [31:0] d);
        bus_write(CON, d);
        m_tx_ie = d[0]; m_rx_ie = d[1];
    endtask

    // Simultaneous read and write of CON: old value returned, both effects.
    task automatic rw_con(logic [31:0] d);
        addr = CON;
        write_data = d;
        mem_read = 1'b1;
        mem_write = 1'b1;
        rd_q.push_back(con_val());
        rd_name_q.push_back("con_rw");
        tick();
        mem_read = 1'b0;
        mem_write = 1'b0;
        addr = 32'd0;
        m_tx_done = 0; m_rx_ovr = 0; m_tx_ovr = 0;
        m_tx_ie = d[0]; m_rx_ie = d[1];
    endtask

    task automatic write_txd(logic [7:0] b);
        if (!m_busy && m_line_idle) begin
            m_tx_data = b;
            m_busy = 1;
            tx_q.push_back(b);
        end else begin
            m_tx_ovr = 1;
        end
        bus_write(TXD, {$urandom_range(0, 255), 16'h0, b});
    endtask

    // UART transmitter model: go busy for a while, then back to idle.
    task automatic finish_tx();
        tx_status = 1'b0;
        ticks($urandom_range(3, 10));
        tx_status = 1'b1;
        ticks(4);
        m_busy = 0;
        m_tx_done = 1;
    endtask

    task automatic do_tx(logic [7:0] b, bit ovr);
        write_txd(b);
        ticks(2);
        if (ovr) begin
            write_txd(8'($urandom));
            read_con();
        end
        finish_tx();
    endtask

    task automatic rx_pulse(logic [7:0] b, int len);
        rx_data = b;
        rx_status = 1'b1;
        ticks(len);
        rx_status = 1'b0;
        ticks(3);
        if (m_rx_ready) m_rx_ovr = 1;
        m_rx_buf = b;
        m_rx_ready = 1;
    endtask

    task automatic check_irq(string nm);
        @(negedge sysclk);
        check(nm, {31'd0, irq}, {31'd0, (m_tx_ie & m_tx_done) | (m_rx_ie & m_rx_ready)});
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        @(negedge sysclk);
        check("rst_rx_enable", {31'd0, rx_enable}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_tx_enable", {31'd0, tx_enable}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        @(posedge sysclk);
        #1;
        reset = 1'b0;
        m_tx_data = 0; m_rx_buf = 0; m_tx_done = 0; m_rx_ready = 0;
        m_rx_ovr = 0; m_tx_ovr = 0; m_tx_ie = 0; m_rx_ie = 0; m_busy = 0;
    endtask

    initial begin
        do_reset();
        ticks(3);
        @(negedge sysclk);
        check("rx_enable_run", {31'd0, rx_enable}, 32'd1);
        @(posedge sysclk);
        #1;
        read_con();
        read_txd();
        read_rxd();
        bus_read(BASE + 32'd12, 32'd0, "unmapped_hi");
        bus_read(BASE - 32'd4, 32'd0, "unmapped_lo");

        // Transmit 0x55 with an overrun attempt of 0xAA while busy.
        write_con(32'd1);
        write_txd(8'h55);
        ticks(2);
        write_txd(8'hAA);
        read_con();
        finish_tx();
        check_irq("irq_tx_done");
        read_txd();
        read_con();
        check_irq("irq_tx_cleared");
        read_con();

        // Long receive pulse delivers exactly one byte.
        write_con(32'd2);
        rx_pulse(8'h3C, 650);
        check_irq("irq_rx_ready");
        read_rxd();
        read_con();
        check_irq("irq_rx_cleared");

        // Two bytes without a read, then a third arriving during an RXD read.
        rx_pulse(8'h11, 5);
        rx_pulse(8'h22, 5);
        read_con();
        rx_data = 8'h33;
        rx_status = 1'b1;
        ticks(2);
        bus_read(RXD, {24'd0, m_rx_buf}, "rxd_coincide");
        m_rx_buf = 8'h33;
        m_rx_ready = 1;
        ticks(3);
        rx_status = 1'b0;
        ticks(3);
        read_con();
        read_rxd();

        // Overrun set on the same edge as a CON read: set wins.
        rx_pulse(8'h44, 4);
        rx_data = 8'h5A;
        rx_status = 1'b1;
        ticks(2);
        read_con();
        m_rx_ovr = 1;
        m_rx_buf = 8'h5A;
        m_rx_ready = 1;
        ticks(3);
        rx_status = 1'b0;
        ticks(3);
        read_con();
        read_rxd();
        rw_con(32'hFFFF_FFFD);
        read_con();

        // Reset while waiting for the transmitter to finish.
        write_txd(8'h77);
        ticks(2);
        tx_status = 1'b0;
        m_line_idle = 1'b0;
        ticks(5);
        do_reset();
        ticks(3);
        read_con();
        read_txd();
        write_txd(8'h88);
        read_con();
        read_txd();
        tx_status = 1'b1;
        ticks(2);
        m_line_idle = 1'b1;
        write_txd(8'h99);
        ticks(2);
        finish_tx();
        read_txd();
        read_con();

        // Randomised mix of transactions.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0: do_tx(8'($urandom), 1'($urandom));
                1: rx_pulse(8'($urandom), $urandom_range(3, 30));
                2: read_rxd();
                3: read_con();
                4: read_txd();
                5: write_con($urandom);
                6: rw_con($urandom);
                default: bus_read(BASE + 32'd12 + 32'($urandom_range(0, 15)) * 32'd4,
                                  32'd0, "unmapped_rand");
            endcase
            check_irq("irq_rand");
        end

        ticks(5);
        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_bus_ctrl.md
UART_BUS_CTRL -- requirements
Module: uart_bus_ctrl

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h40000018, byte address of the TXD register; RXD at BASE_ADDR+4, CON at BASE_ADDR+8.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 sysclk  in  1  system clock; all state changes on posedge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 addr  in  32  CPU byte address.
REQ-006 mem_read  in  1  CPU read strobe, one cycle per access.
REQ-007 mem_write  in  1  CPU write strobe, one cycle per access.
REQ-008 write_data  in  32  CPU write data.
REQ-009 read_data  out  32  CPU read data, combinational from addr/mem_read and register state.
REQ-010 irq  out  1  interrupt request, level.
REQ-011 tx_data  out  8  byte presented to UART transmitter.
REQ-012 tx_enable  out  1  one-cycle send pulse to UART.
REQ-013 tx_status  in  1  UART transmitter idle (1) / busy (0).
REQ-014 rx_data  in  8  UART received byte.
REQ-015 rx_status  in  1  UART receive-done pulse, high ~650 sysclk cycles.
REQ-016 rx_enable  out  1  UART receiver enable.

Function
REQ-017 tx_status and rx_status SHALL each pass through a 2-flop synchronizer (tx_s, rx_s) before use.
REQ-018 A rising edge of rx_s SHALL load rx_data into rx_buf and set rx_ready, exactly once per rx_status pulse.
REQ-019 Rising edge of rx_s while rx_ready=1 SHALL overwrite rx_buf and set rx_overrun.
REQ-020 TX FSM states: TX_IDLE, TX_START, TX_WAIT_BUSY, TX_WAIT_DONE.
REQ-021 TX_IDLE: write to TXD with tx_s=1 SHALL latch write_data[7:0] into tx_data and go TX_START.
REQ-022 TX_START: tx_enable=1 for exactly this one cycle; next state TX_WAIT_BUSY.
REQ-023 TX_WAIT_BUSY: stay until tx_s=0, then TX_WAIT_DONE.
REQ-024 TX_WAIT_DONE: stay until tx_s=1, then set tx_done and go TX_IDLE.
REQ-025 Write to TXD when state!=TX_IDLE or tx_s=0 SHALL be dropped (tx_data unchanged) and set tx_overrun.
REQ-026 Write to CON SHALL update only tx_int_en=write_data[0], rx_int_en=write_data[1].
REQ-027 Read of TXD SHALL return {24'b0, tx_data}; RXD returns {24'b0, rx_buf}; CON returns {25'b0, tx_overrun, rx_overrun, tx_busy, rx_ready, tx_done, rx_int_en, tx_int_en}, tx_busy = (state!=TX_IDLE).
REQ-028 read_data SHALL be 0 when mem_read=0 or addr matches none of the three registers.
REQ-029 Read of RXD SHALL clear rx_ready at the clock edge ending the access.
REQ-030 Read of CON SHALL clear tx_done, rx_overrun, tx_overrun at the clock edge ending the access; returned value is pre-clear.
REQ-031 Simultaneous RXD read and rx_s rising edge: new byte loaded, rx_ready stays 1, rx_overrun not set.
REQ-032 Simultaneous CON read and a set event on a sticky flag: set wins.
REQ-033 irq = (tx_int_en & tx_done) | (rx_int_en & rx_ready).
REQ-034 rx_enable SHALL be 1 whenever reset=0.
REQ-035 mem_read and mem_write both high SHALL perform both the write and the read side effects.

Reset
REQ-036 On reset: state=TX_IDLE, tx_enable=0, tx_data=0, rx_buf=0, all flags and enables 0, synchronizers=1 (idle), rx_enable=0, irq=0.
REQ-037 Reset mid-transmission SHALL abort the FSM to TX_IDLE; later TXD writes are refused (tx_overrun) until tx_s=1.

Verification
REQ-038 Write 0x55 to TXD, UART model idle -> tx_enable one cycle at edge+1, tx_data=0x55, tx_busy=1 until tx_status rises, then tx_done=1; with tx_int_en=1 irq=1; CON read clears it.
REQ-039 Second TXD write 0xAA during busy -> tx_data stays 0x55, CON reads tx_overrun=1, next CON read 0.
REQ-040 rx_status pulse 650 cycles with rx_data=0x3C -> rx_ready=1 once, RXD read returns 0x3C, rx_ready=0 next cycle.
REQ-041 Two rx pulses (0x11, 0x22) with no read -> RXD=0x22, rx_overrun=1; RXD read coinciding with third edge -> rx_ready=1, no overrun.
REQ-042 Reset asserted in TX_WAIT_DONE with tx_status=0 -> all outputs reset values; TXD write post-reset refused until tx_status=1 for 2 cycles.
